// File: rtl/cgra_cfg_loader.sv
// rtl/cgra_cfg_loader.sv - CGRA tile-column configuration frame loader
// Optional CGRA_CFG_CHECK_EN: trailing XOR check word after the last frame.

module cgra_cfg_loader #(
    parameter int FW       = 32,
    parameter int FH       = 2,
    parameter int STRB_LEN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [FW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [FW-1:0] cfg_data,
    output logic [FH-1:0] cfg_strb,
    output logic          clr,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int IW = (FH > 1) ? $clog2(FH) : 1;
    localparam int CW = (STRB_LEN > 1) ? $clog2(STRB_LEN) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(FH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STRB_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          hs;
    logic          launch;
    logic          in_ready_d;
    logic          clr_d;
    logic          busy_d;
    logic          done_d;
    logic [FH-1:0] cfg_strb_d;
    logic [FW-1:0] cfg_data_d;

    assign hs     = in_valid && in_ready;
    assign launch = (state == S_IDLE) && start;

`ifdef CGRA_CFG_CHECK_EN
    logic [FW-1:0] acc, acc_d;
    logic          err_d;
    logic          chk_ok;

    assign chk_ok = (in_data == acc);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    idx_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                state_nxt = S_STROBE;
                cnt_nxt   = '0;
            end
            S_STROBE: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_HOLD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (idx != IDX_LAST) begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = S_LOAD;
                end else begin
`ifdef CGRA_CFG_CHECK_EN
                    state_nxt = S_CHECK;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef CGRA_CFG_CHECK_EN
            S_CHECK: begin
                // A bad check word abandons the load without a done pulse.
                if (hs) begin
                    state_nxt = chk_ok ? S_DONE : S_IDLE;
                end
            end
`endif
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port leaves a flop.
    always_comb begin
        in_ready_d = (state_nxt == S_LOAD) || (state_nxt == S_CHECK);
        busy_d     = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        done_d     = (state_nxt == S_DONE);
        cfg_strb_d = '0;
        for (int i = 0; i < FH; i++) begin
            cfg_strb_d[i] = (state_nxt == S_STROBE) && (idx_nxt == IW'(i));
        end
        cfg_data_d = ((state == S_LOAD) && hs) ? in_data : cfg_data;
        clr_d      = clr;
        if (launch) begin
            clr_d = 1'b1;
        end
        if (state_nxt == S_DONE) begin
            clr_d = 1'b0;
        end
`ifdef CGRA_CFG_CHECK_EN
        acc_d = acc;
        err_d = err;
        if (launch) begin
            acc_d = '0;
            err_d = 1'b0;
        end else if ((state == S_LOAD) && hs) begin
            acc_d = acc ^ in_data;
        end else if ((state == S_CHECK) && hs && !chk_ok) begin
            err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready <= 1'b0;
            cfg_data <= '0;
            cfg_strb <= '0;
            clr      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef CGRA_CFG_CHECK_EN
            acc      <= '0;
            err      <= 1'b0;
`endif
        end else begin
            in_ready <= in_ready_d;
            cfg_data <= cfg_data_d;
            cfg_strb <= cfg_strb_d;
            clr      <= clr_d;
            busy     <= busy_d;
            done     <= done_d;
`ifdef CGRA_CFG_CHECK_EN
            acc      <= acc_d;
            err      <= err_d;
`endif
        end
    end

`ifndef CGRA_CFG_CHECK_EN
    assign err = 1'b0;
`endif

endmodule
